// File: rtl/arp_cam_update_ctrl.sv
// Update/aging controller for the ARP smart CAM: serialises host insert/delete
// and a background aging sweep onto the single CAM/BRAM update port.
module arp_cam_update_ctrl #(
    parameter int K = 32,
    parameter int V = 48,
    parameter int R = 12,
    parameter int A = R + 2,
    parameter int D = K + V + 4,
    parameter int C = 3,
    parameter int U = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqOp,
    input  logic [K-1:0]     ReqKey,
    input  logic [V-1:0]     ReqValue,
    input  logic [4*R-1:0]   ReqHash,
    output logic             RespValid,
    output logic [1:0]       RespStatus,
    output logic [A:0]       RespAddr,
    input  logic             AgingTick,
    output logic             SweepBusy,
    output logic             SweepOverrun,
    output logic [U-1:0]     AgingTimestamp,
    output logic             RamReqValid,
    output logic             RamReqOp,
    output logic [A:0]       RamRwAddr,
    output logic [D-1:0]     RamWrData,
    output logic [U-1:0]     RamWrUsed,
    input  logic [D-1:0]     RamRdData,
    input  logic [U-1:0]     RamRdUsed
);
    localparam int NSRCH = 4 + (1 << C);
    localparam int SW = $clog2(NSRCH + 1);
    localparam int VB = K + V + 2;
    localparam logic [SW-1:0] SRCH_LAST = SW'(NSRCH - 1);
    localparam logic [A:0] SWEEP_LAST = {1'b1, {(A-C){1'b0}}, {C{1'b1}}};

    typedef enum logic [2:0] {IDLE, SRCH, DECIDE, WRITE, RESP, SW_RD, SW_CHK, SW_WR} state_t;
    state_t state, state_nx;

    logic [SW-1:0]   srch_idx;
    logic            req_op;
    logic [K-1:0]    req_key;
    logic [V-1:0]    req_value;
    logic [4*R-1:0]  req_hash;
    logic            match_hit, free_hit, wr_en;
    logic [A:0]      match_addr, free_addr, wr_addr;
    logic [D-1:0]    wr_data;
    logic [U-1:0]    wr_used;
    logic [1:0]      resp_status;
    logic [A:0]      resp_addr;
    logic            sweep_busy, overrun, last_host;
    logic [A:0]      sweep_idx;
    logic [U-1:0]    sweep_ts, aging_ts;

    logic            grant_host, grant_sweep, evaluating, cur_hit, cur_free;
    logic            fin_hit, fin_free, sweep_adv;
    logic [A:0]      cur_addr, fin_maddr, fin_faddr;
    logic [U-1:0]    age_used;

    // Search order: ways 0..3 at their hashed rows, then every overflow CAM slot.
    function automatic logic [A:0] srch_addr(input logic [SW-1:0] j, input logic [4*R-1:0] h);
        logic [A:0]    a;
        logic [SW-1:0] c;
        c = j - SW'(4);
        if (j < 4) a = {1'b0, j[1:0], h[(3 - int'(j[1:0])) * R +: R]};
        else       a = {1'b1, {(A-C){1'b0}}, c[C-1:0]};
        return a;
    endfunction

    function automatic logic [D-1:0] make_entry(input logic [K-1:0] k, input logic [V-1:0] v);
        logic [D-1:0] e;
        e = '0;
        e[K-1:0]   = k;
        e[K+V-1:K] = v;
        e[VB]      = 1'b1;
        return e;
    endfunction

    assign grant_host  = (state == IDLE) && ReqValid && !Rst && !(last_host && sweep_busy);
    assign grant_sweep = (state == IDLE) && sweep_busy && !grant_host;
    assign ReqReady    = grant_host;

    always_comb begin
        evaluating = ((state == SRCH) && (srch_idx != '0)) || (state == DECIDE);
        cur_addr   = srch_addr(srch_idx - 1'b1, req_hash);
        cur_hit    = evaluating && RamRdData[VB] && (RamRdData[K-1:0] == req_key);
        cur_free   = evaluating && !RamRdData[VB];
        fin_hit    = match_hit || cur_hit;
        fin_maddr  = match_hit ? match_addr : cur_addr;
        fin_free   = free_hit || cur_free;
        fin_faddr  = free_hit ? free_addr : cur_addr;
        age_used   = RamRdUsed & ~sweep_ts;
        sweep_adv  = ((state == SW_CHK) && !RamRdData[VB]) || (state == SW_WR);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            srch_idx    <= '0;
            match_hit   <= 1'b0;
            free_hit    <= 1'b0;
            wr_en       <= 1'b0;
            resp_status <= '0;
            resp_addr   <= '0;
            sweep_busy  <= 1'b0;
            sweep_idx   <= '0;
            aging_ts    <= U'(1);
            overrun     <= 1'b0;
            last_host   <= 1'b0;
        end else begin
            state   <= state_nx;
            overrun <= AgingTick && sweep_busy;
            if (AgingTick && !sweep_busy) begin
                sweep_busy <= 1'b1;
                sweep_ts   <= aging_ts;
            end
            if (grant_host)       last_host <= 1'b1;
            else if (grant_sweep) last_host <= 1'b0;

            if (sweep_adv) begin
                if (sweep_idx == SWEEP_LAST) begin
                    sweep_idx  <= '0;
                    sweep_busy <= 1'b0;
                    aging_ts   <= {aging_ts[U-2:0], aging_ts[U-1]};
                end else begin
                    sweep_idx <= sweep_idx + 1'b1;
                end
            end

            case (state)
                IDLE: if (grant_host) begin
                    req_op    <= ReqOp;
                    req_key   <= ReqKey;
                    req_value <= ReqValue;
                    req_hash  <= ReqHash;
                    srch_idx  <= '0;
                    match_hit <= 1'b0;
                    free_hit  <= 1'b0;
                end
                SRCH: begin
                    srch_idx <= srch_idx + 1'b1;
                    if (cur_hit && !match_hit) begin
                        match_hit  <= 1'b1;
                        match_addr <= cur_addr;
                    end
                    if (cur_free && !free_hit) begin
                        free_hit  <= 1'b1;
                        free_addr <= cur_addr;
                    end
                end
                DECIDE: begin
                    wr_en     <= 1'b0;
                    resp_addr <= '0;
                    if (!req_op) begin
                        wr_data <= make_entry(req_key, req_value);
                        wr_used <= ~aging_ts;
                        if (fin_hit) begin
                            wr_en <= 1'b1; wr_addr <= fin_maddr; resp_addr <= fin_maddr; resp_status <= 2'd1;
                        end else if (fin_free) begin
                            wr_en <= 1'b1; wr_addr <= fin_faddr; resp_addr <= fin_faddr; resp_status <= 2'd0;
                        end else begin
                            resp_status <= 2'd3;
                        end
                    end else begin
                        wr_data <= '0;
                        wr_used <= '0;
                        if (fin_hit) begin
                            wr_en <= 1'b1; wr_addr <= fin_maddr; resp_addr <= fin_maddr; resp_status <= 2'd1;
                        end else begin
                            resp_status <= 2'd2;
                        end
                    end
                end
                SW_CHK: if (RamRdData[VB]) begin
                    wr_data <= (age_used == '0) ? '0 : RamRdData;
                    wr_used <= age_used;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        RamReqValid = 1'b0;
        RamReqOp    = 1'b0;
        RamRwAddr   = '0;
        RamWrData   = '0;
        RamWrUsed   = '0;
        case (state)
            IDLE:   if (grant_host) state_nx = SRCH;
                    else if (grant_sweep) state_nx = SW_RD;
            SRCH: begin
                RamReqValid = 1'b1;
                RamRwAddr   = srch_addr(srch_idx, req_hash);
                if (srch_idx == SRCH_LAST) state_nx = DECIDE;
            end
            DECIDE: state_nx = WRITE;
            WRITE: begin
                state_nx = RESP;
                if (wr_en) begin
                    RamReqValid = 1'b1;
                    RamReqOp    = 1'b1;
                    RamRwAddr   = wr_addr;
                    RamWrData   = wr_data;
                    RamWrUsed   = wr_used;
                end
            end
            RESP:   state_nx = IDLE;
            SW_RD: begin
                RamReqValid = 1'b1;
                RamRwAddr   = sweep_idx;
                state_nx    = SW_CHK;
            end
            SW_CHK: state_nx = RamRdData[VB] ? SW_WR : IDLE;
            SW_WR: begin
                RamReqValid = 1'b1;
                RamReqOp    = 1'b1;
                RamRwAddr   = sweep_idx;
                RamWrData   = wr_data;
                RamWrUsed   = wr_used;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign RespValid      = (state == RESP);
    assign RespStatus     = resp_status;
    assign RespAddr       = resp_addr;
    assign SweepBusy      = sweep_busy;
    assign SweepOverrun   = overrun;
    assign AgingTimestamp = aging_ts;

endmodule

// File: tb/tb_arp_cam_update_ctrl.sv
// Directed bench for arp_cam_update_ctrl with a small table (R=2) and a
// behavioural BRAM+CAM model on the update port.
module tb_arp_cam_update_ctrl;
    localparam int K = 32, V = 48, R = 2, A = 4, D = 84, C = 3, U = 8;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic           ReqValid = 1'b0, ReqOp = 1'b0;
    logic [K-1:0]   ReqKey = '0;
    logic [V-1:0]   ReqValue = '0;
    logic [4*R-1:0] ReqHash = '0;
    logic           AgingTick = 1'b0;
    logic           ReqReady, RespValid, SweepBusy, SweepOverrun;
    logic [1:0]     RespStatus;
    logic [A:0]     RespAddr, RamRwAddr;
    logic [U-1:0]   AgingTimestamp, RamWrUsed, RamRdUsed;
    logic           RamReqValid, RamReqOp;
    logic [D-1:0]   RamWrData, RamRdData;

    arp_cam_update_ctrl #(.K(K), .V(V), .R(R), .A(A), .D(D), .C(C), .U(U)) dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqKey(ReqKey), .ReqValue(ReqValue), .ReqHash(ReqHash), .RespValid(RespValid),
        .RespStatus(RespStatus), .RespAddr(RespAddr), .AgingTick(AgingTick),
        .SweepBusy(SweepBusy), .SweepOverrun(SweepOverrun), .AgingTimestamp(AgingTimestamp),
        .RamReqValid(RamReqValid), .RamReqOp(RamReqOp), .RamRwAddr(RamRwAddr),
        .RamWrData(RamWrData), .RamWrUsed(RamWrUsed), .RamRdData(RamRdData), .RamRdUsed(RamRdUsed)
    );

    always #5 Clk = ~Clk;

    logic [D-1:0] mem  [0:23];
    logic [U-1:0] umem [0:23];
    int cyc = 0, n_acc = 0, resp_cnt = 0, wr_cnt = 0;
    int acc_t [0:127];

    function automatic int midx(input logic [A:0] a);
        return a[A] ? 16 + int'(a[C-1:0]) : int'(a[A-1:0]);
    endfunction

    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 24; i++) begin
                mem[i]  <= '0;
                umem[i] <= '0;
            end
        end else if (RamReqValid) begin
            if (RamReqOp) begin
                mem[midx(RamRwAddr)]  <= RamWrData;
                umem[midx(RamRwAddr)] <= RamWrUsed;
            end else begin
                RamRdData <= mem[midx(RamRwAddr)];
                RamRdUsed <= umem[midx(RamRwAddr)];
            end
        end
    end

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (ReqValid && ReqReady) begin
            if (n_acc < 128) acc_t[n_acc] <= cyc;
            n_acc <= n_acc + 1;
        end
        if (RespValid) resp_cnt <= resp_cnt + 1;
        if (RamReqValid && RamReqOp) wr_cnt <= wr_cnt + 1;
    end

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int lat;
    logic [1:0] r_status;
    logic [A:0] r_addr;

    task automatic host_op(input logic op, input logic [K-1:0] key, input logic [V-1:0] val,
                           input logic [4*R-1:0] hash);
        int n;
        @(negedge Clk);
        ReqValid = 1'b1; ReqOp = op; ReqKey = key; ReqValue = val; ReqHash = hash;
        #1;
        n = 0;
        while (!ReqReady && n < 200) begin
            @(negedge Clk); #1; n++;
        end
        if (!ReqReady) check("ready_tmo", ReqReady, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        ReqValid = 1'b0;
        lat = 1;
        while (!RespValid && lat < 40) begin
            @(negedge Clk); lat++;
        end
        r_status = RespStatus;
        r_addr   = RespAddr;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [D-1:0]   ent;
    logic [K-1:0]   k;
    logic [A:0]     ea;
    logic [U-1:0]   exp_ts, exp_used;
    int w0, base, n, nvalid;

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_ready", ReqReady, 1'b0);
        check("rst_respvalid", RespValid, 1'b0);
        check("rst_status", RespStatus, 2'd0);
        check("rst_respaddr", RespAddr, '0);
        check("rst_busy", SweepBusy, 1'b0);
        check("rst_overrun", SweepOverrun, 1'b0);
        check("rst_ts", AgingTimestamp, 8'h01);
        check("rst_ramvalid", RamReqValid, 1'b0);
        check("rst_ramop", RamReqOp, 1'b0);
        check("rst_ramaddr", RamRwAddr, '0);
        check("rst_wrdata", RamWrData, '0);
        check("rst_wrused", RamWrUsed, '0);
        Rst = 1'b0;

        // insert into empty table: way0 row 1
        host_op(1'b0, 32'h0A000001, 48'h0011_2233_4455, 8'h6C);
        check("ins_status", r_status, 2'd0);
        check("ins_addr", r_addr, 5'h01);
        check("ins_latency", lat, 15);
        ent = {4'b0100, 48'h0011_2233_4455, 32'h0A000001};
        check("ins_mem", mem[1], ent);
        check("ins_used", umem[1], 8'hFE);

        w0 = wr_cnt;
        host_op(1'b0, 32'h0A000001, 48'hAABB_CCDD_EEFF, 8'h6C);
        check("upd_status", r_status, 2'd1);
        check("upd_addr", r_addr, 5'h01);
        check("upd_latency", lat, 15);
        check("upd_writes", wr_cnt - w0, 1);
        check("upd_mem", mem[1], {4'b0100, 48'hAABB_CCDD_EEFF, 32'h0A000001});
        nvalid = 0;
        for (int i = 0; i < 24; i++) if (mem[i][82]) nvalid++;
        check("upd_single", nvalid, 1);

        host_op(1'b1, 32'h0A000001, 48'h0, 8'h6C);
        check("del_status", r_status, 2'd1);
        check("del_addr", r_addr, 5'h01);
        check("del_mem", mem[1], '0);
        check("del_used", umem[1], 8'h00);
        host_op(1'b1, 32'h0A000001, 48'h0, 8'h6C);
        check("del_absent", r_status, 2'd2);

        host_op(1'b0, 32'h0A000001, 48'h0011_2233_4455, 8'h6C);
        check("reins_status", r_status, 2'd0);
        check("reins_addr", r_addr, 5'h01);

        // 12 keys colliding on hash 2 in every way: 4 BRAM rows then 8 CAM slots
        for (int i = 0; i < 12; i++) begin
            k = 32'hC0A80001 + i;
            host_op(1'b0, k, 48'h1000 + i, 8'hAA);
            ea = (i < 4) ? 5'(4 * i + 2) : 5'(16 + i - 4);
            check("fill_status", r_status, 2'd0);
            check("fill_addr", r_addr, ea);
        end
        w0 = wr_cnt;
        host_op(1'b0, 32'hC0A800FF, 48'h1, 8'hAA);
        check("full_status", r_status, 2'd3);
        check("full_latency", lat, 15);
        check("full_nowrite", wr_cnt - w0, 0);
        host_op(1'b1, 32'hC0A800FE, 48'h0, 8'hAA);
        check("del_notfound", r_status, 2'd2);

        // eight sweeps with no lookups: one used bit cleared each, evicted on the 8th
        exp_ts = 8'h01;
        for (int s = 1; s <= 8; s++) begin
            @(negedge Clk); AgingTick = 1'b1;
            @(negedge Clk); AgingTick = 1'b0;
            if (s == 1) check("sweep_busy_set", SweepBusy, 1'b1);
            n = 0;
            while (SweepBusy && n < 1000) begin
                @(negedge Clk); n++;
            end
            check("sweep_done", SweepBusy, 1'b0);
            exp_ts = {exp_ts[6:0], exp_ts[7]};
            check("sweep_ts", AgingTimestamp, exp_ts);
            if (s < 8) begin
                exp_used = 8'hFF;
                exp_used = exp_used << s;
                check("age_used", umem[1], exp_used);
                if (s == 1) check("age_data", mem[1], ent);
            end else begin
                check("evict_valid", mem[1][82], 1'b0);
                check("evict_used", umem[1], 8'h00);
                check("evict_cam", mem[16], '0);
            end
        end

        // continuous host traffic during a sweep: host and sweep entries alternate
        base = n_acc;
        @(negedge Clk);
        ReqValid = 1'b1; ReqOp = 1'b1; ReqKey = 32'hDEAD0000; ReqHash = 8'h1B;
        repeat (3) @(negedge Clk);
        AgingTick = 1'b1;
        @(negedge Clk); AgingTick = 1'b0;
        repeat (30) @(negedge Clk);
        check("ovr_busy", SweepBusy, 1'b1);
        AgingTick = 1'b1;
        @(negedge Clk); AgingTick = 1'b0;
        check("ovr_pulse", SweepOverrun, 1'b1);
        @(negedge Clk);
        check("ovr_clear", SweepOverrun, 1'b0);
        n = 0;
        while (n_acc < base + 31 && n < 3000) begin
            @(negedge Clk); n++;
        end
        check("arb_count", n_acc >= base + 31, 1'b1);
        check("arb_gap0", acc_t[base+1] - acc_t[base], 19);
        check("arb_gap1", acc_t[base+2] - acc_t[base+1], 19);
        check("arb_gap_after", acc_t[base+30] - acc_t[base+29], 16);
        check("arb_resp", RespStatus, 2'd2);
        check("ovr_done", SweepBusy, 1'b0);
        check("ovr_ts", AgingTimestamp, 8'h02);
        ReqValid = 1'b0;
        repeat (20) @(negedge Clk);
        check("ovr_nosweep", SweepBusy, 1'b0);
        check("ovr_ts_hold", AgingTimestamp, 8'h02);

        // reset in the middle of a search
        @(negedge Clk);
        ReqValid = 1'b1; ReqOp = 1'b0; ReqKey = 32'h0B000001; ReqValue = 48'h5; ReqHash = 8'h1B;
        #1;
        check("rst_accept", ReqReady, 1'b1);
        @(negedge Clk); ReqValid = 1'b0;
        repeat (2) @(negedge Clk);
        check("srch_read", RamReqValid, 1'b1);
        w0 = wr_cnt; n = resp_cnt;
        Rst = 1'b1;
        @(negedge Clk);
        check("abort_ramvalid", RamReqValid, 1'b0);
        check("abort_ramaddr", RamRwAddr, '0);
        check("abort_ready", ReqReady, 1'b0);
        check("abort_resp", RespValid, 1'b0);
        check("abort_ts", AgingTimestamp, 8'h01);
        Rst = 1'b0;
        repeat (20) @(negedge Clk);
        check("abort_noresp", resp_cnt - n, 0);
        check("abort_nowrite", wr_cnt - w0, 0);
        check("abort_busy", SweepBusy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arp_cam_update_ctrl.md
# arp_cam_update_ctrl

Update and aging controller for the ARP IPv4→MAC smart CAM: owns the CAM/BRAM update port (RamReq*/RamWr*/RamRd*) of the lookup block and the aging timestamp it consumes. Serialises host insert/delete requests and a background aging sweep onto that single port, searching the four hash ways plus the 8-entry overflow CAM before writing. Sits between the ARP table management logic and the smart-CAM lookup datapath.

## Interface
- K, 32, key width (IPv4 address)
- V, 48, value width (MAC)
- A, 14, BRAM address bits (2 way bits + R)
- R, 12, per-way hash/address bits
- D, 84, entry width: [31:0] key, [79:32] value, [82] valid, [80],[81],[83] written 0
- C, 3, overflow CAM address bits
- U, 8, used/timestamp width
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- ReqValid  in  1  host request valid
- ReqReady  out  1  accept; transfer when ReqValid & ReqReady
- ReqOp  in  1  0=insert/update, 1=delete
- ReqKey  in  K  key
- ReqValue  in  V  value (insert only)
- ReqHash  in  4*R  way hashes, {way0,way1,way2,way3} MSB-first
- RespValid  out  1  one-cycle response pulse
- RespStatus  out  2  0=inserted new, 1=updated/deleted, 2=not found, 3=table full
- RespAddr  out  A+1  location written/matched (MSB 1 = CAM)
- AgingTick  in  1  pulse: start one aging sweep
- SweepBusy  out  1  sweep in progress
- SweepOverrun  out  1  one-cycle pulse: AgingTick while SweepBusy
- AgingTimestamp  out  U  one-hot current epoch to lookup block
- RamReqValid, RamReqOp  out  1,1  update-port request, 0=read 1=write
- RamRwAddr  out  A+1  MSB 0=BRAM, 1=CAM
- RamWrData  out  D;  RamWrUsed  out  U
- RamRdData  in  D;  RamRdUsed  in  U  valid the cycle after a read request

## Operation
- One transaction at a time. Arbiter in IDLE: host wins unless the previous granted transaction was host and a sweep is pending (alternate host/sweep entry).
- Reads drive RamWrData=0 (no false bubble hits in lookup block); writes drive full entry.
- Insert/delete (states SRCH→DECIDE→WRITE→RESP): latch request; issue 12 back-to-back reads: BRAM {w,ReqHash_w} w=0..3, then CAM 0..7. On each returning word: key match with valid → record match (first wins); invalid → record first free (BRAM ways before CAM).
- DECIDE insert: match → write entry at match, status 1; else free → write there, status 0; else no write, status 3. RamWrUsed = ~AgingTimestamp.
- DECIDE delete: match → write D'0 with RamWrUsed=0, status 1; else no write, status 2.
- Aging sweep (SW_RD→SW_CHK→SW_WR): latch T=AgingTimestamp on AgingTick; walk BRAM 0..2^A-1 then CAM 0..7. Entry invalid → no write. Valid: n = RamRdUsed & ~T; n==0 → write D'0, used 0 (evict); else write same data, used n. On completion rotate AgingTimestamp left by 1, drop SweepBusy.
- AgingTick while SweepBusy: ignored, SweepOverrun pulses.

## Timing
- Reset: ReqReady 0, RespValid 0, RespStatus 0, RespAddr 0, SweepBusy 0, SweepOverrun 0, AgingTimestamp 8'h01, RamReqValid 0, RamReqOp 0, RamRwAddr 0, RamWrData 0, RamWrUsed 0; state IDLE, sweep index 0. Rst mid-transaction aborts with no further port activity; no response issued.
- ReqReady high only in IDLE when host is granted that cycle; combinational with grant.
- Host op: accept cycle 0, reads cycles 1–12, last data cycle 13, DECIDE 13, write (if any) cycle 14, RespValid cycle 15. Latency accept→RespValid = 15 always.
- Sweep entry: read t, check t+1, write t+2 (valid) → 3 cycles; invalid → 2 cycles. Back to IDLE between entries for arbitration (+1 cycle).
- RamReqValid is a single-cycle strobe per access; never two accesses in one cycle.
- Sweep index counter A+1 bits; wraps to 0 at completion.

## Test plan
- Insert key 0x0A000001 value 0x0011_2233_4455, hashes all distinct, empty table → write at {0,hash0}, RespStatus 0, RespValid exactly 15 cycles after accept.
- Re-insert same key value 0xAABB_CCDD_EEFF → write same address, status 1, no second entry.
- Fill ways 0–3 of a hash and all 8 CAM slots, insert 13th colliding key → no write, status 3; delete an absent key → status 2.
- Insert entry, AgingTick with T=8'h01, no lookups → used 8'hFE→8'hFE after sweep 1, bits cleared one per sweep, evicted (valid 0) on 8th sweep; AgingTimestamp rotates 01→02→…→80→01.
- Continuous ReqValid during sweep → grants alternate host/sweep entry; AgingTick mid-sweep → SweepOverrun pulse, sweep count unchanged.
- Assert Rst during SRCH → all outputs at reset values next cycle, no RespValid, AgingTimestamp 8'h01.
